// File: rtl/imem_req_if.sv
// Requester-side bundle for one port of the instruction-memory arbiter.
// Request: req_valid/req_addr in, req_ready back (combinational grant).
// Response: one-entry slot rsp_valid/rsp_data/rsp_err out, rsp_ready back.
// master = requester (fetch or debug), slave = arbiter.
interface imem_req_if #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 32
);
  logic         req_valid;
  logic [N-1:0] req_addr;
  logic         req_ready;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         rsp_ready;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter for a single combinational instruction-memory read port.
// Port p0 is the CPU fetch path, p1 the debug/loader path. Each accepted
// request is answered one cycle later through a one-entry response slot.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   p0, p1           imem_req_if.slave request/response bundles
//   imem_addr        word address to imem (combinational on a grant)
//   imem_q           imem read data, combinational from imem_addr
//   busy_cnt         saturating count of cycles with both ports requesting
// Build option: define IMEM_ARB_FETCH_PRIO_EN for strict fetch priority,
// otherwise round-robin between the two ports.
module imem_arbiter #(
  parameter int unsigned N     = 32,
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_req_if.slave     p0,
  imem_req_if.slave     p1,
  output logic [AW-1:0] imem_addr,
  input  logic [W-1:0]  imem_q,
  output logic [15:0]   busy_cnt
);

  localparam int unsigned IW = N - 2;

  typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           elig0, elig1;
  logic           grant0, grant1, grant_any;
  logic [N-1:0]   addr_g;
  logic [IW-1:0]  idx_g;
  logic           oor_g;
  logic [W-1:0]   word_g;
  logic [AW-1:0]  addr_q;

  // A slot is free when empty or being popped this cycle; nothing is
  // eligible while reset is asserted so outputs stay at reset values.
  assign elig0 = reset && p0.req_valid && (!p0.rsp_valid || p0.rsp_ready);
  assign elig1 = reset && p1.req_valid && (!p1.rsp_valid || p1.rsp_ready);

  // Grant-pointer next state and grant selection.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state_q;
`ifdef IMEM_ARB_FETCH_PRIO_EN
    grant0 = elig0;
    grant1 = elig1 && !elig0;
`else
    if (elig0 && elig1) begin
      grant0 = (state_q == LAST1);
      grant1 = (state_q == LAST0);
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
`endif
    if (grant0) begin
      state_d = LAST0;
    end else if (grant1) begin
      state_d = LAST1;
    end
  end

  // Last-grant register; resets to LAST1 so fetch wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LAST1;
    end else begin
      state_q <= state_d;
    end
  end

  assign p0.req_ready = grant0;
  assign p1.req_ready = grant1;
  assign grant_any    = grant0 || grant1;

  // Address decode for the granted port; misaligned or past-the-end
  // addresses return zero with the error flag instead of imem data.
  assign addr_g    = grant1 ? p1.req_addr : p0.req_addr;
  assign idx_g     = addr_g[N-1:2];
  assign oor_g     = (idx_g >= IW'(DEPTH)) || (addr_g[1:0] != 2'b00);
  assign word_g    = oor_g ? '0 : imem_q;
  assign imem_addr = grant_any ? idx_g[AW-1:0] : addr_q;

  // Holds the last driven imem address across idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else if (grant_any) begin
      addr_q <= idx_g[AW-1:0];
    end
  end

  // Port 0 response slot; a grant overrides a same-cycle pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0.rsp_valid <= 1'b0;
      p0.rsp_data  <= '0;
      p0.rsp_err   <= 1'b0;
    end else if (grant0) begin
      p0.rsp_valid <= 1'b1;
      p0.rsp_data  <= word_g;
      p0.rsp_err   <= oor_g;
    end else if (p0.rsp_ready) begin
      p0.rsp_valid <= 1'b0;
    end
  end

  // Port 1 response slot; a grant overrides a same-cycle pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1.rsp_valid <= 1'b0;
      p1.rsp_data  <= '0;
      p1.rsp_err   <= 1'b0;
    end else if (grant1) begin
      p1.rsp_valid <= 1'b1;
      p1.rsp_data  <= word_g;
      p1.rsp_err   <= oor_g;
    end else if (p1.rsp_ready) begin
      p1.rsp_valid <= 1'b0;
    end
  end

  // Contention counter, counts raw request overlap and saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= '0;
    end else if (p0.req_valid && p1.req_valid && (busy_cnt != 16'hFFFF)) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

endmodule
